pulse_stretcher: RTL and testbench

Output-side conditioning: turns single-cycle or short internal event strobes (bus activity, key-press flags, UART frame-done) into clean, human-visible pulses on LEDs or panel outputs. Input conditioning turns a noisy level into clean transitions; this block turns clean transitions into timed, glitch-free levels. It guarantees a minimum high time and a minimum low gap, so back-to-back events stay distinguishable. It sits between core logic and top-level indicator pins, one instance per output.

---
 rtl/pulse_stretch_pkg.sv | 22 ++
 rtl/rise_detect.sv | 23 ++
 rtl/pulse_stretcher.sv | 138 +++++++++++++
 tb/tb_pulse_stretcher.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/pulse_stretch_pkg.sv
// Shared types and helpers for the pulse stretcher: FSM state encoding and
// counter-width calculation.
package pulse_stretch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    GAP  = 2'd2
  } state_t;

  // Counter must hold the larger of the two phase lengths minus one.
  function automatic int cnt_width_f(input int on_cycles, input int off_cycles);
    int max_v;
    if (on_cycles > off_cycles) begin
      max_v = on_cycles;
    end else begin
      max_v = off_cycles;
    end
    return $clog2(max_v + 32'sd1);
  endfunction

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector for an already-synchronous trigger. The history register
// resets high so a level held through reset release is not taken as an event.
module rise_detect (
  input  logic CLK,
  input  logic RESET,
  input  logic trigger,
  output logic rise
);

  logic prev_r;

  // Previous-cycle trigger value.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      prev_r <= 1'b1;
    end else begin
      prev_r <= trigger;
    end
  end

  assign rise = trigger & ~prev_r;

endmodule

// File: rtl/pulse_stretcher.sv
// Stretches trigger rising edges into pulses of ON_CYCLES high followed by at
// least OFF_CYCLES low. Define PULSE_STRETCH_RETRIGGER_EN to extend a pulse on events during ON.
module pulse_stretcher
  import pulse_stretch_pkg::*;
#(
  parameter int ON_CYCLES  = 8,
  parameter int OFF_CYCLES = 4
) (
  input  logic CLK,
  input  logic RESET,
  input  logic trigger,
  output logic pulse_out,
  output logic busy,
  output logic trans_up,
  output logic trans_dn
);

  localparam int CNT_W = cnt_width_f(ON_CYCLES, OFF_CYCLES);
  localparam logic [CNT_W-1:0] ON_LOAD  = CNT_W'(ON_CYCLES - 32'sd1);
  localparam logic [CNT_W-1:0] OFF_LOAD = CNT_W'(OFF_CYCLES - 32'sd1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(1'b0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);

  state_t           state_r, state_nxt_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic             pend_r, pend_nxt_s;
  logic             rise_s;
  logic             pulse_out_r, busy_r, trans_up_r, trans_dn_r;
  logic             pulse_nxt_s, busy_nxt_s, up_nxt_s, dn_nxt_s;

  rise_detect u_rise (
    .CLK     (CLK),
    .RESET   (RESET),
    .trigger (trigger),
    .rise    (rise_s)
  );

  // State, counter, pending flag and registered outputs.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r     <= IDLE;
      cnt_r       <= CNT_ZERO;
      pend_r      <= 1'b0;
      pulse_out_r <= 1'b0;
      busy_r      <= 1'b0;
      trans_up_r  <= 1'b0;
      trans_dn_r  <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      pend_r      <= pend_nxt_s;
      pulse_out_r <= pulse_nxt_s;
      busy_r      <= busy_nxt_s;
      trans_up_r  <= up_nxt_s;
      trans_dn_r  <= dn_nxt_s;
    end
  end

  // Next-state, counter and pending-flag logic.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    pend_nxt_s  = pend_r;
    case (state_r)
      IDLE: begin
        if (rise_s) begin
          state_nxt_s = ON;
          cnt_nxt_s   = ON_LOAD;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ON: begin
`ifdef PULSE_STRETCH_RETRIGGER_EN
        if (rise_s) begin
          cnt_nxt_s = ON_LOAD;
        end else if (cnt_r == CNT_ZERO) begin
          state_nxt_s = GAP;
          cnt_nxt_s   = OFF_LOAD;
        end else begin
          cnt_nxt_s = cnt_r - CNT_ONE;
        end
`else
        if (rise_s) begin
          pend_nxt_s = 1'b1;
        end else begin
          pend_nxt_s = pend_r;
        end
        if (cnt_r == CNT_ZERO) begin
          state_nxt_s = GAP;
          cnt_nxt_s   = OFF_LOAD;
        end else begin
          cnt_nxt_s = cnt_r - CNT_ONE;
        end
`endif
      end
      GAP: begin
        // An event in the final gap cycle starts the next pulse without waiting.
        if (cnt_r == CNT_ZERO) begin
          pend_nxt_s = 1'b0;
          if (pend_r | rise_s) begin
            state_nxt_s = ON;
            cnt_nxt_s   = ON_LOAD;
          end else begin
            state_nxt_s = IDLE;
            cnt_nxt_s   = CNT_ZERO;
          end
        end else begin
          cnt_nxt_s = cnt_r - CNT_ONE;
          if (rise_s) begin
            pend_nxt_s = 1'b1;
          end else begin
            pend_nxt_s = pend_r;
          end
        end
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = CNT_ZERO;
        pend_nxt_s  = 1'b0;
      end
    endcase
  end

  // Output values for the next cycle, derived from the transition being taken.
  always_comb begin
    pulse_nxt_s = (state_nxt_s == ON);
    busy_nxt_s  = (state_nxt_s != IDLE) | pend_nxt_s;
    up_nxt_s    = (state_nxt_s == ON) && (state_r != ON);
    dn_nxt_s    = (state_r == ON) && (state_nxt_s != ON);
  end

  assign pulse_out = pulse_out_r;
  assign busy      = busy_r;
  assign trans_up  = trans_up_r;
  assign trans_dn  = trans_dn_r;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Randomized bench for pulse_stretcher: two instances (3/2 and 1/1 cycles) checked
// against a timeline model that tracks pulse start/end and gap-end cycle numbers.
module tb_pulse_stretcher;

  localparam int ON_A = 3, OFF_A = 2, ON_B = 1, OFF_B = 1;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       trigger = 1'b0;
  logic [1:0] pulse_out, busy, trans_up, trans_dn;

  always #5 CLK = ~CLK;

  pulse_stretcher #(.ON_CYCLES(ON_A), .OFF_CYCLES(OFF_A)) u_dut_a (
    .CLK(CLK), .RESET(RESET), .trigger(trigger),
    .pulse_out(pulse_out[0]), .busy(busy[0]), .trans_up(trans_up[0]), .trans_dn(trans_dn[0])
  );

  pulse_stretcher #(.ON_CYCLES(ON_B), .OFF_CYCLES(OFF_B)) u_dut_b (
    .CLK(CLK), .RESET(RESET), .trigger(trigger),
    .pulse_out(pulse_out[1]), .busy(busy[1]), .trans_up(trans_up[1]), .trans_dn(trans_dn[1])
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  int on_len [2] = '{ON_A, ON_B};
  int off_len[2] = '{OFF_A, OFF_B};
  int on_start[2], on_until[2], gap_until[2];
  bit pending[2];
  bit prev_trig;

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%b want=%b", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset(input int k);
    on_start[k]  = -100;
    on_until[k]  = -100;
    gap_until[k] = -100;
    pending[k]   = 1'b0;
  endtask

  task automatic start_pulse(input int k, input int c);
    on_start[k]  = c + 1;
    on_until[k]  = c + on_len[k];
    gap_until[k] = c + on_len[k] + off_len[k];
  endtask

  // Advance the timeline of instance k by the cycle c in which ev was seen.
  task automatic model_step(input int k, input bit ev, input int c);
    bit in_on, in_gap;
    in_on  = (c >= on_start[k]) && (c <= on_until[k]);
    in_gap = (c > on_until[k]) && (c <= gap_until[k]);
    if (in_gap && c == gap_until[k] && (pending[k] || ev)) begin
      start_pulse(k, c);
      pending[k] = 1'b0;
    end else if (ev) begin
      if (in_on) begin
`ifdef PULSE_STRETCH_RETRIGGER_EN
        on_until[k]  = c + on_len[k];
        gap_until[k] = c + on_len[k] + off_len[k];
`else
        pending[k] = 1'b1;
`endif
      end else if (in_gap) begin
        pending[k] = 1'b1;
      end else begin
        start_pulse(k, c);
      end
    end
  endtask

  task automatic step(input logic trg, input logic rst);
    bit ev;
    trigger = trg;
    RESET   = rst;
    @(posedge CLK);
    if (rst) begin
      ev = 1'b0;
      prev_trig = 1'b1;
      for (int k = 0; k < 2; k++) model_reset(k);
    end else begin
      ev = trg && !prev_trig;
      prev_trig = trg;
      for (int k = 0; k < 2; k++) model_step(k, ev, cyc);
    end
    cyc++;
    #1;
    for (int k = 0; k < 2; k++) begin
      check_bit($sformatf("pulse_out[%0d]", k), pulse_out[k],
                (cyc >= on_start[k]) && (cyc <= on_until[k]));
      check_bit($sformatf("trans_up[%0d]", k), trans_up[k], cyc == on_start[k]);
      check_bit($sformatf("trans_dn[%0d]", k), trans_dn[k], cyc == on_until[k] + 1);
      check_bit($sformatf("busy[%0d]", k), busy[k], (cyc <= gap_until[k]) || pending[k]);
    end
    @(negedge CLK);
  endtask

  task automatic idle(input int n, input logic trg);
    for (int i = 0; i < n; i++) step(trg, 1'b0);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) model_reset(k);
    prev_trig = 1'b1;
    @(negedge CLK);
    idle(0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
    idle(5, 1'b0);
    // Single event.
    step(1'b1, 1'b0);
    idle(12, 1'b0);
    // Two events two cycles apart.
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    idle(14, 1'b0);
    // Level held for 20 cycles: one pulse only.
    idle(20, 1'b1);
    idle(10, 1'b0);
    // Event pending, then reset with trigger held high across release.
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    idle(10, 1'b1);
    idle(4, 1'b0);
    // Event in the very cycle the FSM returns to IDLE, then every-other-cycle edges.
    step(1'b1, 1'b0);
    idle(ON_A + OFF_A, 1'b0);
    step(1'b1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b0);
      step(1'b1, 1'b0);
    end
    idle(10, 1'b0);
    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      step(logic'($urandom_range(0, 99) < 40), logic'($urandom_range(0, 249) == 0));
    end
    idle(10, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
